// File: rtl/q_max_reader.sv
// q_max_reader
//
// Read side of the Q-table. On `start`, the block sweeps every action of one
// state through a synchronous-read Q-table port. It returns:
//   - the signed maximum Q(s,a) (the max_q_next operand of the Q16.16 update),
//   - the lowest-index action that achieves that maximum (the greedy action),
//   - Q(s, sel_action), captured during the same sweep (the q_old operand).
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset; aborts any sweep
//   start        sweep request, sampled only while idle
//   state_in     state to sweep, captured with start
//   sel_action   action whose Q is also returned, captured with start
//   busy         high whenever a sweep is in progress (READ/DRAIN/DONE)
//   done         one-cycle pulse; max_q/best_action/q_sel are valid
//   max_q        max over a of Q(s,a), signed Q16.16
//   best_action  lowest action index achieving max_q
//   q_sel        Q(s, sel_action); 0 if sel_action >= NUM_ACTIONS
//   rd_en        Q-table read enable
//   rd_addr      Q-table address {state, action}; holds when rd_en is low
//   rd_data      Q-table read data, valid the cycle after rd_en/rd_addr
module q_max_reader #(
    parameter int STATE_W     = 4,
    parameter int ACTION_W    = 2,
    parameter int NUM_ACTIONS = 4,
    parameter int DATA_W      = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [STATE_W-1:0]          state_in,
    input  logic [ACTION_W-1:0]         sel_action,
    output logic                        busy,
    output logic                        done,
    output logic [DATA_W-1:0]           max_q,
    output logic [ACTION_W-1:0]         best_action,
    output logic [DATA_W-1:0]           q_sel,
    output logic                        rd_en,
    output logic [STATE_W+ACTION_W-1:0] rd_addr,
    input  logic [DATA_W-1:0]           rd_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ACTION_W-1:0] LAST_IDX = ACTION_W'(NUM_ACTIONS - 1);

    // Strict signed compare: ties return 0 so the earlier (lower) action wins.
    function automatic logic signed_gt(input logic signed [DATA_W-1:0] a,
                                       input logic signed [DATA_W-1:0] b);
        return a > b;
    endfunction

    state_t                 state;
    state_t                 state_nxt;
    logic                   accept;

    logic [STATE_W-1:0]     s_lat;
    logic [ACTION_W-1:0]    sel_lat;
    logic [ACTION_W-1:0]    idx;

    logic                   vld_p1;
    logic [ACTION_W-1:0]    act_p1;
    logic signed [DATA_W-1:0] data_p1;

    logic signed [DATA_W-1:0] run_max_p2;
    logic [ACTION_W-1:0]    run_act_p2;
    logic [DATA_W-1:0]      run_sel_p2;

    logic signed [DATA_W-1:0] cand_max;
    logic [ACTION_W-1:0]    cand_act;
    logic [DATA_W-1:0]      cand_sel;

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address stays {s_lat, idx}; both only move on accept or in READ, so the
    // address naturally holds its last value while rd_en is low.
    assign rd_addr = {s_lat, idx};

    always_ff @(posedge clk) begin
        if (rst) begin
            s_lat   <= '0;
            sel_lat <= '0;
            idx     <= '0;
            vld_p1  <= 1'b0;
            act_p1  <= '0;
        end else begin
            vld_p1 <= rd_en;
            act_p1 <= idx;
            if (accept) begin
                s_lat   <= state_in;
                sel_lat <= sel_action;
                idx     <= '0;
            end else if (state == READ && idx != LAST_IDX) begin
                idx <= idx + ACTION_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage p1: RAM word returns; fold it into the running max / q_sel
    // ---------------------------------------------------------------
    assign data_p1 = rd_data;

    always_comb begin
        cand_max = run_max_p2;
        cand_act = run_act_p2;
        cand_sel = run_sel_p2;
        if (vld_p1) begin
            // Action 0 seeds the max so no sentinel minimum is needed.
            if (act_p1 == '0 || signed_gt(data_p1, run_max_p2)) begin
                cand_max = data_p1;
                cand_act = act_p1;
            end
            // Out-of-range sel_lat never matches, leaving the cleared 0.
            if (act_p1 == sel_lat) begin
                cand_sel = rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            run_sel_p2 <= '0;
        end else if (vld_p1) begin
            run_max_p2 <= cand_max;
            run_act_p2 <= cand_act;
            run_sel_p2 <= cand_sel;
        end
    end

    // ---------------------------------------------------------------
    // Stage p2: publish results on entry to DONE, otherwise hold
    // ---------------------------------------------------------------
    // DRAIN is the cycle that folds in the last word, so the combinational
    // candidate (not the running register) carries the final answer.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_q       <= '0;
            best_action <= '0;
            q_sel       <= '0;
        end else if (state == DRAIN) begin
            max_q       <= cand_max;
            best_action <= cand_act;
            q_sel       <= cand_sel;
        end
    end

endmodule

// File: tb/tb_q_max_reader.sv
// Directed bench for q_max_reader: a behavioural synchronous-read Q-table
// feeds the DUT; expected values are hand-computed constants.
module tb_q_max_reader;

    localparam int STATE_W     = 4;
    localparam int ACTION_W    = 2;
    localparam int NUM_ACTIONS = 4;
    localparam int DATA_W      = 32;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        start;
    logic [STATE_W-1:0]          state_in;
    logic [ACTION_W-1:0]         sel_action;
    logic                        busy;
    logic                        done;
    logic [DATA_W-1:0]           max_q;
    logic [ACTION_W-1:0]         best_action;
    logic [DATA_W-1:0]           q_sel;
    logic                        rd_en;
    logic [STATE_W+ACTION_W-1:0] rd_addr;
    logic [DATA_W-1:0]           rd_data = '0;

    logic [DATA_W-1:0] qtab [0:63];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= qtab[rd_addr];
    end

    q_max_reader #(
        .STATE_W(STATE_W), .ACTION_W(ACTION_W),
        .NUM_ACTIONS(NUM_ACTIONS), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in),
        .sel_action(sel_action), .busy(busy), .done(done), .max_q(max_q),
        .best_action(best_action), .q_sel(q_sel), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; state_in = '0; sel_action = '0;
        tick; tick;
        vectors++;
        if ({busy, done, rd_en} !== 3'b000) begin
            miscompares++; $display("FAIL reset_ctrl: got busy/done/rd_en=%b want 000", {busy, done, rd_en});
        end
        vectors++;
        if (rd_addr !== 6'h00 || best_action !== 2'd0) begin
            miscompares++; $display("FAIL reset_addr: got rd_addr=%h best=%0d want 00/0", rd_addr, best_action);
        end
        vectors++;
        if (max_q !== 32'h0 || q_sel !== 32'h0) begin
            miscompares++; $display("FAIL reset_data: got max_q=%h q_sel=%h want 0/0", max_q, q_sel);
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick;
            vectors++;
            if (rd_en !== 1'b0 || busy !== 1'b0) begin
                miscompares++; $display("FAIL idle_cycle%0d: got rd_en=%b busy=%b want 0/0", c, rd_en, busy);
            end
        end
    endtask

    task automatic test_basic;
        logic [5:0] exp_addr [0:3];
        exp_addr[0] = 6'h14; exp_addr[1] = 6'h15; exp_addr[2] = 6'h16; exp_addr[3] = 6'h17;
        state_in = 4'd5; sel_action = 2'd2; start = 1'b1;
        tick;                                   // T+1
        start = 1'b0; state_in = 4'd9; sel_action = 2'd0;   // must not disturb sweep
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (rd_en !== 1'b1 || rd_addr !== exp_addr[k]) begin
                miscompares++; $display("FAIL basic_read%0d: got rd_en=%b addr=%h want 1/%h", k, rd_en, rd_addr, exp_addr[k]);
            end
            tick;
        end
        // T+5 (DRAIN)
        vectors++;
        if ({busy, done, rd_en} !== 3'b100) begin
            miscompares++; $display("FAIL basic_drain: got busy/done/rd_en=%b want 100", {busy, done, rd_en});
        end
        tick;                                   // T+6
        vectors++;
        if (done !== 1'b1 || max_q !== 32'h00018000 || best_action !== 2'd1 || q_sel !== 32'hFFFF0000) begin
            miscompares++; $display("FAIL basic_result: got done=%b max=%h best=%0d qsel=%h want 1/00018000/1/ffff0000",
                                    done, max_q, best_action, q_sel);
        end
        tick;                                   // T+7
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || max_q !== 32'h00018000) begin
            miscompares++; $display("FAIL basic_after: got done=%b busy=%b max=%h want 0/0/00018000", done, busy, max_q);
        end
    endtask

    task automatic test_output_hold;
        state_in = 4'd0; sel_action = 2'd0; start = 1'b1;
        tick;                                   // T+1
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            vectors++;
            if (max_q !== 32'h00018000 || best_action !== 2'd1 || done !== 1'b0) begin
                miscompares++; $display("FAIL hold_T+%0d: got max=%h best=%0d done=%b want 00018000/1/0", c, max_q, best_action, done);
            end
            tick;
        end
        vectors++;
        if (done !== 1'b1 || max_q !== 32'h0 || best_action !== 2'd0 || q_sel !== 32'h0) begin
            miscompares++; $display("FAIL hold_result: got done=%b max=%h best=%0d qsel=%h want 1/0/0/0", done, max_q, best_action, q_sel);
        end
        tick;
    endtask

    task automatic test_negative_tie;
        state_in = 4'd15; sel_action = 2'd3; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;                        // T+6
        vectors++;
        if (done !== 1'b1 || max_q !== 32'hFFFFC000 || best_action !== 2'd1 || q_sel !== 32'hFFFE0000) begin
            miscompares++; $display("FAIL neg_tie: got done=%b max=%h best=%0d qsel=%h want 1/ffffc000/1/fffe0000",
                                    done, max_q, best_action, q_sel);
        end
        tick;
    endtask

    task automatic test_start_while_busy;
        state_in = 4'd5; sel_action = 2'd1; start = 1'b1;
        tick;                                   // T+1
        start = 1'b0;
        tick;                                   // T+2
        start = 1'b1; state_in = 4'd3;
        tick;                                   // T+3
        start = 1'b0;
        vectors++;
        if (rd_addr !== 6'h16) begin
            miscompares++; $display("FAIL busy_start_addr: got rd_addr=%h want 16", rd_addr);
        end
        tick; tick;                             // T+5
        vectors++;
        if (done !== 1'b0) begin
            miscompares++; $display("FAIL busy_early_done: got done=%b want 0", done);
        end
        tick;                                   // T+6
        vectors++;
        if (done !== 1'b1 || max_q !== 32'h00018000 || best_action !== 2'd1 || q_sel !== 32'h00018000) begin
            miscompares++; $display("FAIL busy_result: got done=%b max=%h best=%0d qsel=%h want 1/00018000/1/00018000",
                                    done, max_q, best_action, q_sel);
        end
        tick;                                   // T+7: idle, nothing queued
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL busy_not_queued: got done=%b busy=%b want 0/0", done, busy);
        end
        start = 1'b1; state_in = 4'd3; sel_action = 2'd0;
        tick;                                   // T'+1
        start = 1'b0;
        vectors++;
        if (rd_en !== 1'b1 || rd_addr !== 6'h0C) begin
            miscompares++; $display("FAIL b2b_addr: got rd_en=%b addr=%h want 1/0c", rd_en, rd_addr);
        end
        repeat (5) tick;                        // T'+6
        vectors++;
        if (done !== 1'b1 || max_q !== 32'h7FFFFFFF || best_action !== 2'd3 || q_sel !== 32'h00000100) begin
            miscompares++; $display("FAIL b2b_result: got done=%b max=%h best=%0d qsel=%h want 1/7fffffff/3/00000100",
                                    done, max_q, best_action, q_sel);
        end
        tick;
    endtask

    task automatic test_reset_mid_sweep;
        int seen;
        int lat;
        state_in = 4'd15; sel_action = 2'd0; start = 1'b1;
        tick;                                   // T+1
        start = 1'b0;
        tick; tick;                             // T+3
        rst = 1'b1;
        tick;                                   // T+4
        vectors++;
        if (rd_en !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL midrst_ctrl: got rd_en=%b busy=%b want 0/0", rd_en, busy);
        end
        vectors++;
        if (max_q !== 32'h0 || best_action !== 2'd0 || q_sel !== 32'h0) begin
            miscompares++; $display("FAIL midrst_outputs: got max=%h best=%0d qsel=%h want 0/0/0", max_q, best_action, q_sel);
        end
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick;
            if (done === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++; $display("FAIL midrst_no_done: got %0d done pulses want 0", seen);
        end
        state_in = 4'd5; sel_action = 2'd2; start = 1'b1;
        tick;                                   // T+1
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 12) begin
            tick;
            lat++;
        end
        vectors++;
        if (lat != 6) begin
            miscompares++; $display("FAIL midrst_latency: got %0d cycles want 6", lat);
        end
        vectors++;
        if (max_q !== 32'h00018000 || best_action !== 2'd1 || q_sel !== 32'hFFFF0000) begin
            miscompares++; $display("FAIL midrst_result: got max=%h best=%0d qsel=%h want 00018000/1/ffff0000",
                                    max_q, best_action, q_sel);
        end
        tick;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) qtab[i] = '0;
        qtab[6'h14] = 32'h00008000; qtab[6'h15] = 32'h00018000;
        qtab[6'h16] = 32'hFFFF0000; qtab[6'h17] = 32'h00010000;
        qtab[6'h3C] = 32'hFFFF8000; qtab[6'h3D] = 32'hFFFFC000;
        qtab[6'h3E] = 32'hFFFFC000; qtab[6'h3F] = 32'hFFFE0000;
        qtab[6'h0C] = 32'h00000100; qtab[6'h0D] = 32'h00000300;
        qtab[6'h0E] = 32'h00000200; qtab[6'h0F] = 32'h7FFFFFFF;

        test_reset;
        test_basic;
        test_output_hold;
        test_negative_tie;
        test_start_while_busy;
        test_reset_mid_sweep;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
